// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, issues one I-cache request at a time, and
// hands fetched instructions to decode through an output register plus skid.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_req_addr,
  output logic        icache_req_valid,
  input  logic [31:0] icache_rsp_data,
  input  logic        icache_rsp_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, KILL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        req_valid_q, req_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic [31:0] redir_pc;
  logic        slot_free;

  assign redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign slot_free = ~id_valid_q | id_ready;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_target_d  = pc_target_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;

    if (id_valid_q && id_ready) id_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) pc_d = redir_pc;
      end
      FETCH: begin
        if (icache_rsp_ready) begin
          if (redirect_valid) begin
            pc_d = redir_pc;
          end else begin
            if (slot_free) begin
              id_valid_d = 1'b1;
              id_inst_d  = icache_rsp_data;
              id_pc_d    = pc_q;
            end else begin
              skid_valid_d = 1'b1;
              skid_inst_d  = icache_rsp_data;
              skid_pc_d    = pc_q;
              state_d      = FULL;
            end
            pc_d = pc_q + 32'd4;
          end
        end else if (redirect_valid) begin
          pc_target_d = redir_pc;
          state_d     = KILL;
        end
      end
      FULL: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end else if (id_ready && skid_valid_q) begin
          id_valid_d   = 1'b1;
          id_inst_d    = skid_inst_q;
          id_pc_d      = skid_pc_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      KILL: begin
        // The request in flight is stale; its response only frees the bus.
        if (icache_rsp_ready) begin
          pc_d    = redirect_valid ? redir_pc : pc_target_q;
          state_d = FETCH;
        end else if (redirect_valid) begin
          pc_target_d = redir_pc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end

    req_valid_d = (state_d == FETCH) || (state_d == KILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pc_target_q  <= 32'd0;
      req_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= 32'd0;
      skid_pc_q    <= 32'd0;
      id_valid_q   <= 1'b0;
      id_inst_q    <= 32'd0;
      id_pc_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_target_q  <= pc_target_d;
      req_valid_q  <= req_valid_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
    end
  end

  assign icache_req_addr  = pc_q;
  assign icache_req_valid = req_valid_q;
  assign id_valid         = id_valid_q;
  assign id_inst          = id_inst_q;
  assign id_pc            = id_pc_q;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly upstream of the instruction cache. It owns the program counter and issues one word-aligned fetch request at a time to the I-cache over a valid/ready handshake. It delivers each returned instruction, tagged with its PC, to the decode stage through a two-entry (output + skid) buffer. It accepts single-cycle branch/jump redirects from later stages and discards any in-flight fetch the redirect makes stale.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- icache_req_addr  out  32  fetch address (= PC register), word aligned
- icache_req_valid  out  1  fetch request outstanding
- icache_rsp_data  in  32  instruction word, valid only when icache_rsp_ready=1
- icache_rsp_ready  in  1  one-cycle pulse: request for icache_req_addr completed
- redirect_valid  in  1  one-cycle pulse: fetch must restart at redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
- id_valid  out  1  id_inst/id_pc hold an instruction for decode
- id_inst  out  32  instruction to decode
- id_pc  out  32  address of id_inst
- id_ready  in  1  decode accepts the output this cycle (transfer = id_valid & id_ready)

## Operation
- State machine with four states: IDLE, FETCH, FULL, KILL.
- icache_req_valid = 1 in FETCH and KILL, 0 otherwise.
- While icache_req_valid=1 and no rsp has arrived, icache_req_addr is held stable. The address changes only on the edge that samples icache_rsp_ready=1.
- IDLE: entered on reset; moves to FETCH on the next edge unconditionally.
- FETCH, rsp arrives, no redirect:
  - If the output slot is free (id_valid=0 or id_ready=1), load id_inst/id_pc and set id_valid=1.
  - Otherwise write {data, pc} into the skid register and go to FULL.
  - In both cases pc <= pc+4 (32-bit wrap; 0xFFFF_FFFC -> 0x0000_0000).
- FETCH, redirect without rsp: pc_target <= redirect_pc, go to KILL.
- KILL: the outstanding request is still held at the old address. When rsp arrives it is discarded, pc <= pc_target, go to FETCH.
- Redirect in the same cycle as a rsp (FETCH or KILL): rsp is discarded, pc <= redirect_pc, go to FETCH.
- Redirect while already in KILL without rsp: pc_target is overwritten (newest wins).
- FULL: no request. When id_ready=1, output <= skid, skid cleared, go to FETCH.
- Any redirect, in any state:
  - Clears id_valid and the skid on the same edge.
  - An instruction presented that cycle is not counted as transferred.
  - From FULL or IDLE, go to FETCH with pc <= redirect_pc.
- When id_valid=1 and id_ready=0 with no incoming rsp, the output holds its values.
- A transfer with no refill clears id_valid.
- Instructions reach decode in strict PC order with no duplicates. Nothing fetched before a redirect is delivered after it.

## Timing
- Reset (edge with rst=1):
  - state=IDLE, pc=RESET_PC, pc_target=0, skid empty.
  - id_valid=0, id_inst=0, id_pc=0.
  - icache_req_valid=0, icache_req_addr=RESET_PC.
- rst asserted mid-request aborts everything; a rsp in the reset cycle is ignored.
- First icache_req_valid=1 occurs in the 2nd cycle after the last rst=1 edge.
- Latency: rsp sampled at edge N -> id_valid=1 with that instruction after edge N. The next request address is visible after edge N.
- Throughput: 1 instruction/cycle when the cache answers every cycle and decode never stalls.
- Redirect sampled at edge N with no request outstanding -> icache_req_addr=redirect_pc after edge N.
- Redirect sampled at edge N with a request outstanding -> icache_req_addr=redirect_pc after the edge where the stale rsp is sampled.

## Test plan
- Reset release, cache always ready, id_ready=1 -> addresses 0x0, 0x4, 0x8, … on consecutive cycles; id_pc follows one cycle behind with matching id_inst.
- Decode stalls (id_ready=0) for 3 cycles while rsp for 0x10 and 0x14 arrive:
  - 0x10 stays on output; 0x14 goes to skid; state FULL; icache_req_valid=0.
  - On id_ready=1, 0x14 is presented next and fetch resumes at 0x18.
- Miss of 5 cycles on 0x20, redirect to 0x100 in cycle 2:
  - Address holds 0x20 until rsp; that rsp is dropped (id_valid stays 0).
  - Next request is 0x100.
- Redirect to 0x203 in the same cycle as rsp for 0x40 -> 0x40 never appears on id_*; next request is 0x200.
- Redirect while in FULL holding 0x50 and 0x54 -> id_valid=0 after the edge; skid empty; fetch from the target.
- PC 0xFFFF_FFFC returns -> next request 0x0000_0000; rst pulsed mid-miss -> all outputs return to reset values and fetch restarts at RESET_PC.
